// File: rtl/spi_crc_pkg.sv
// Shared SD-card CRC constants for the SPI CRC manager.
package spi_crc_pkg;

    // CRC7 generator x^7 + x^3 + 1 (implicit x^7 term)
    localparam logic [6:0]  SD_CRC7_POLY   = 7'h09;
    // CRC16-CCITT generator x^16 + x^12 + x^5 + 1
    localparam logic [15:0] SD_CRC16_POLY  = 16'h1021;
    // CRC16 register value after reset
    localparam logic [15:0] SD_CRC16_INIT  = 16'h0000;
    // SD command frames always end with a 1 bit
    localparam logic        SD_CMD_END_BIT = 1'b1;

endpackage

// File: rtl/serial_crc_lfsr.sv
// Bit-serial Galois CRC register, MSB-first, no reflection, no final XOR.
// Updates on the falling edge of clk; synchronous active-high reset.
module serial_crc_lfsr #(
    parameter int unsigned           WIDTH = 7,
    parameter logic [WIDTH-1:0]      POLY  = '0,
    parameter logic [WIDTH-1:0]      INIT  = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             din,
    output logic [WIDTH-1:0] crc
);

    logic [WIDTH-1:0] crc_q;
    logic [WIDTH-1:0] crc_d;
    logic             fb;

    // Next CRC value: shift left and fold in the polynomial when feedback is set
    always_comb begin
        fb    = din ^ crc_q[WIDTH-1];
        crc_d = crc_q;
        if (en) begin
            crc_d = {crc_q[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
    end

    // CRC state register, reset has priority over shifting
    always_ff @(negedge clk) begin
        if (reset) begin
            crc_q <= INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/spi_crc_manager.sv
// SD-card SPI CRC manager: running CRC7 (command trailer) and CRC16-CCITT
// (data block) computed from MOSI, one bit per falling edge of spi_clk.
// Optional feature macro: SPI_CRC_MANAGER_CRC16_EN builds the CRC16 path;
// when undefined, crc16 is tied to zero.
module spi_crc_manager
    import spi_crc_pkg::*;
#(
    parameter logic [6:0]  CRC7_POLY  = SD_CRC7_POLY,
    parameter logic [15:0] CRC16_POLY = SD_CRC16_POLY,
    parameter logic [15:0] CRC16_INIT = SD_CRC16_INIT
) (
    input  logic        spi_clk,
    input  logic        reset,
    input  logic        en,
    input  logic        mosi,
    output logic [7:0]  crc8,
    output logic [15:0] crc16
);

    logic [6:0] crc7;

    serial_crc_lfsr #(
        .WIDTH (7),
        .POLY  (CRC7_POLY),
        .INIT  (7'h00)
    ) u_crc7 (
        .clk   (spi_clk),
        .reset (reset),
        .en    (en),
        .din   (mosi),
        .crc   (crc7)
    );

    assign crc8 = {crc7, SD_CMD_END_BIT};

`ifdef SPI_CRC_MANAGER_CRC16_EN
    serial_crc_lfsr #(
        .WIDTH (16),
        .POLY  (CRC16_POLY),
        .INIT  (CRC16_INIT)
    ) u_crc16 (
        .clk   (spi_clk),
        .reset (reset),
        .en    (en),
        .din   (mosi),
        .crc   (crc16)
    );
`else
    // CRC16 parameters stay referenced so the parameter list is the same in both builds
    logic [31:0] unused_crc16_cfg;
    assign unused_crc16_cfg = {CRC16_POLY, CRC16_INIT};
    assign crc16 = '0;
`endif

endmodule

// File: tb/tb_spi_crc_manager.sv
// Directed self-checking bench for spi_crc_manager.
module tb_spi_crc_manager;

    logic        spi_clk = 1'b0;
    logic        clk_gate = 1'b1;
    logic        reset = 1'b0;
    logic        en = 1'b0;
    logic        mosi = 1'b0;
    logic [7:0]  crc8;
    logic [15:0] crc16;

    int unsigned tests_run = 0;
    int unsigned tests_failed = 0;

    spi_crc_manager dut (
        .spi_clk (spi_clk),
        .reset   (reset),
        .en      (en),
        .mosi    (mosi),
        .crc8    (crc8),
        .crc16   (crc16)
    );

    // Gateable clock so idle-clock gaps can be exercised
    initial begin
        forever begin
            #5;
            if (clk_gate) spi_clk = ~spi_clk;
        end
    end

    // Absolute time bound for the whole run
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Expected CRC16 depends on whether the CRC16 path is built
    function automatic logic [15:0] exp16(input logic [15:0] v);
`ifdef SPI_CRC_MANAGER_CRC16_EN
        return v;
`else
        return 16'h0000;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests_run++;
        if (obs !== expv) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // Present one bit while the clock is high; it is absorbed on the falling edge
    task automatic shift_bit(input logic b, input logic en_v);
        @(posedge spi_clk);
        #1;
        mosi = b;
        en   = en_v;
        @(negedge spi_clk);
        #1;
        en   = 1'b0;
    endtask

    task automatic shift_byte(input logic [7:0] b, input logic en_v);
        for (int i = 7; i >= 0; i--) shift_bit(b[i], en_v);
    endtask

    task automatic do_reset(input int unsigned n);
        @(posedge spi_clk);
        #1;
        reset = 1'b1;
        en    = 1'b0;
        repeat (n) @(negedge spi_clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic idle_cycles(input int unsigned n);
        repeat (n) @(negedge spi_clk);
        #1;
    endtask

    task automatic clock_stop(input int unsigned t);
        clk_gate = 1'b0;
        #(t);
        clk_gate = 1'b1;
    endtask

    logic [7:0] cmd0 [5];
    logic [7:0] cmd8 [5];

    initial begin
        cmd0[0] = 8'h40; cmd0[1] = 8'h00; cmd0[2] = 8'h00; cmd0[3] = 8'h00; cmd0[4] = 8'h00;
        cmd8[0] = 8'h48; cmd8[1] = 8'h00; cmd8[2] = 8'h00; cmd8[3] = 8'h01; cmd8[4] = 8'hAA;

        // Reset state
        do_reset(2);
        check("reset_crc8", {24'h0, crc8}, 32'h01);
        check("reset_crc16", {16'h0, crc16}, {16'h0, exp16(16'h0000)});

        // Single 1 bit: crc7 = 0x09 -> crc8 = 0x13; crc16 = 0x1021, visible right after the edge
        shift_bit(1'b1, 1'b1);
        check("one_bit_crc8", {24'h0, crc8}, 32'h13);
        check("one_bit_crc16", {16'h0, crc16}, {16'h0, exp16(16'h1021)});

        // CMD0
        do_reset(1);
        for (int i = 0; i < 5; i++) shift_byte(cmd0[i], 1'b1);
        check("cmd0_crc8", {24'h0, crc8}, 32'h95);
        idle_cycles(5);
        check("cmd0_hold", {24'h0, crc8}, 32'h95);

        // CMD8
        do_reset(1);
        for (int i = 0; i < 5; i++) shift_byte(cmd8[i], 1'b1);
        check("cmd8_crc8", {24'h0, crc8}, 32'h87);

        // CMD8 with disabled idle cycles between bytes
        do_reset(1);
        for (int i = 0; i < 5; i++) begin
            shift_byte(cmd8[i], 1'b1);
            idle_cycles(i * 3 + 1);
        end
        check("cmd8_idle_gaps", {24'h0, crc8}, 32'h87);

        // CMD8 with the clock stopped between bytes
        do_reset(1);
        for (int i = 0; i < 5; i++) begin
            shift_byte(cmd8[i], 1'b1);
            clock_stop(17 + i * 23);
        end
        check("cmd8_clk_stop", {24'h0, crc8}, 32'h87);

        // CRC16 check value over "123456789"
        do_reset(1);
        check("pre_ascii_crc16", {16'h0, crc16}, {16'h0, exp16(16'h0000)});
        for (int i = 0; i < 9; i++) shift_byte(8'h31 + 8'(i), 1'b1);
        check("ascii_crc16", {16'h0, crc16}, {16'h0, exp16(16'h31C3)});

        // 512-byte block of 0xFF
        do_reset(1);
        for (int i = 0; i < 512; i++) shift_byte(8'hFF, 1'b1);
        check("ff_block_crc16", {16'h0, crc16}, {16'h0, exp16(16'h7FA1)});

        // en gating: a byte shifted with en low is ignored
        do_reset(1);
        shift_byte(8'h48, 1'b1);
        shift_byte(8'h00, 1'b0);
        shift_byte(8'h00, 1'b1);
        shift_byte(8'h00, 1'b1);
        shift_byte(8'h01, 1'b1);
        shift_byte(8'hAA, 1'b1);
        check("en_gating_crc8", {24'h0, crc8}, 32'h87);

        // Mid-frame reset with en high: reset wins, bit dropped
        do_reset(1);
        shift_bit(1'b1, 1'b1);
        shift_bit(1'b0, 1'b1);
        shift_bit(1'b1, 1'b1);
        @(posedge spi_clk);
        #1;
        reset = 1'b1;
        en    = 1'b1;
        mosi  = 1'b1;
        @(negedge spi_clk);
        #1;
        reset = 1'b0;
        en    = 1'b0;
        check("mid_reset_crc8", {24'h0, crc8}, 32'h01);
        check("mid_reset_crc16", {16'h0, crc16}, {16'h0, exp16(16'h0000)});
        for (int i = 0; i < 5; i++) shift_byte(cmd0[i], 1'b1);
        check("mid_reset_cmd0", {24'h0, crc8}, 32'h95);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
